// File: rtl/velocity_mem_pkg.sv
// Shared widths, copy-engine state type and count saturation helper for the
// double-buffered velocity store.
package velocity_mem_pkg;

    localparam int unsigned DefDataWidth   = 96;
    localparam int unsigned DefParticleNum = 220;
    localparam int unsigned DefAddrWidth   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCopy,
        StTail
    } cp_state_e;

    function automatic int unsigned sat_count(input int unsigned val, input int unsigned max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/velocity_bank_ram.sv
// Simple dual-port RAM bank: one write port, one read port with a registered
// (1-cycle) read. No reset on the array or read register.
module velocity_bank_ram #(
    parameter int unsigned DATA_WIDTH = 96,
    parameter int unsigned DEPTH      = 220,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    // Callers only present addresses below DEPTH, so the low bits suffice.
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IdxW-1:0]       widx;
    logic [IdxW-1:0]       ridx;

    assign widx = waddr_i[IdxW-1:0];
    assign ridx = raddr_i[IdxW-1:0];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[ridx];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/velocity_cell_pingpong.sv
// Ping-pong per-cell velocity store: the active bank serves reads, the shadow
// bank takes writes/appends, and a copy engine can mirror active into shadow.
module velocity_cell_pingpong
    import velocity_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned PARTICLE_NUM = DefParticleNum,
    parameter int unsigned ADDR_WIDTH   = DefAddrWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  app_en_i,
    input  logic [DATA_WIDTH-1:0] app_data_i,
    output logic                  app_full_o,
    output logic                  ovf_o,
    input  logic                  swap_i,
    input  logic                  cp_req_i,
    output logic                  busy_o,
    output logic                  cp_done_o,
    output logic                  active_bank_o,
    output logic [ADDR_WIDTH-1:0] active_count_o
);

    localparam int unsigned         MaxCount = PARTICLE_NUM - 1;
    localparam logic [ADDR_WIDTH-1:0] MaxCnt = ADDR_WIDTH'(MaxCount);
    localparam logic [ADDR_WIDTH:0]   NumW   = (ADDR_WIDTH + 1)'(PARTICLE_NUM);

    cp_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] n_q, n_d;
    logic                  cp_wr_q;
    logic [ADDR_WIDTH-1:0] cp_waddr_q;
    logic                  cp_done_q;

    logic                          active_bank_q, active_bank_d;
    logic [1:0][ADDR_WIDTH-1:0]    cnt_q, cnt_d;
    logic                          ovf_q, ovf_d;

    logic                  rd_valid_q;
    logic                  rd_ram_q;
    logic                  rd_bank_q;
    logic [DATA_WIDTH-1:0] rd_word_q;

    logic                  busy;
    logic                  shadow;
    logic [ADDR_WIDTH-1:0] act_cnt;
    logic [ADDR_WIDTH-1:0] sh_cnt;
    logic                  app_full;
    logic                  rd_accept;
    logic                  rd_hit;
    logic                  wr_in_range;

    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic                  ram_we;
    logic                  ram_wbank;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata [2];

    assign busy     = (state_q != StIdle);
    assign shadow   = ~active_bank_q;
    assign act_cnt  = cnt_q[active_bank_q];
    assign sh_cnt   = cnt_q[shadow];
    assign app_full = (sh_cnt == MaxCnt);

    assign rd_accept   = rd_en_i & ~busy;
    assign rd_hit      = (rd_addr_i != '0) && (rd_addr_i <= act_cnt) && ({1'b0, rd_addr_i} < NumW);
    assign wr_in_range = (wr_addr_i != '0) && ({1'b0, wr_addr_i} < NumW);

    // The copy engine owns the active read port while busy; user reads are
    // rejected then, so there is never a port conflict.
    assign ram_re    = (state_q == StCopy) | (rd_accept & rd_hit);
    assign ram_raddr = (state_q == StCopy) ? ptr_q : rd_addr_i;

    always_comb begin
        ram_we    = 1'b0;
        ram_wbank = shadow;
        ram_waddr = '0;
        ram_wdata = '0;
        if (cp_wr_q) begin
            ram_we    = 1'b1;
            ram_wbank = ~rd_bank_q;
            ram_waddr = cp_waddr_q;
            ram_wdata = ram_rdata[rd_bank_q];
        end else if (!busy) begin
            if (app_en_i) begin
                if (!app_full) begin
                    ram_we    = 1'b1;
                    ram_waddr = sh_cnt + 1'b1;
                    ram_wdata = app_data_i;
                end
            end else if (wr_en_i && wr_in_range) begin
                ram_we    = 1'b1;
                ram_waddr = wr_addr_i;
                ram_wdata = wr_data_i;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        n_d           = n_q;
        cnt_d         = cnt_q;
        active_bank_d = active_bank_q;
        ovf_d         = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (cp_req_i) begin
                    n_d     = act_cnt;
                    ptr_d   = ADDR_WIDTH'(1);
                    state_d = (act_cnt == '0) ? StTail : StCopy;
                end
            end
            StCopy: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == n_q) begin
                    state_d = StTail;
                end
            end
            StTail: begin
                cnt_d[shadow] = n_q;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (!busy) begin
            if (app_en_i) begin
                if (app_full) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d[shadow] = sh_cnt + 1'b1;
                end
            end else if (wr_en_i && (wr_addr_i == '0)) begin
                cnt_d[shadow] = ADDR_WIDTH'(sat_count(int'(wr_data_i[ADDR_WIDTH-1:0]), MaxCount));
            end
            // Write/append above target the pre-swap shadow; the old active
            // bank becomes the new, empty shadow.
            if (swap_i) begin
                active_bank_d        = ~active_bank_q;
                cnt_d[active_bank_q] = '0;
                ovf_d                = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            n_q           <= '0;
            cp_wr_q       <= 1'b0;
            cp_waddr_q    <= '0;
            cp_done_q     <= 1'b0;
            active_bank_q <= 1'b0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_ram_q      <= 1'b0;
            rd_bank_q     <= 1'b0;
            rd_word_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            n_q           <= n_d;
            cp_wr_q       <= (state_q == StCopy);
            cp_waddr_q    <= ptr_q;
            cp_done_q     <= (state_q == StTail);
            active_bank_q <= active_bank_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            rd_valid_q    <= rd_accept;
            rd_ram_q      <= rd_accept & rd_hit;
            rd_bank_q     <= active_bank_q;
            rd_word_q     <= (rd_accept && (rd_addr_i == '0)) ? DATA_WIDTH'(act_cnt) : '0;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        velocity_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (PARTICLE_NUM),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk_i   (clk_i),
            .we_i    (ram_we && (ram_wbank == 1'(b))),
            .waddr_i (ram_waddr),
            .wdata_i (ram_wdata),
            .re_i    (ram_re && (active_bank_q == 1'(b))),
            .raddr_i (ram_raddr),
            .rdata_o (ram_rdata[b])
        );
    end

    assign rd_data_o      = rd_ram_q ? ram_rdata[rd_bank_q] : rd_word_q;
    assign rd_valid_o     = rd_valid_q;
    assign app_full_o     = app_full;
    assign ovf_o          = ovf_q;
    assign busy_o         = busy;
    assign cp_done_o      = cp_done_q;
    assign active_bank_o  = active_bank_q;
    assign active_count_o = act_cnt;

endmodule
